mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Iterative RISC-V M-extension multiply/divide unit for the out-of-order execution cluster. Accepts one operation at a time from the MUL/DIV reservation station over a valid/ready handshake.
- Computes all eight RV32M/RV64M operations by shift-add or restoring division on operand magnitudes, then applies a final sign correction.
- Returns an XLEN result plus the issuing tag to the CDB arbiter over a second valid/ready handshake. Supports pipeline flush.

Parameters:
- XLEN, 32, operand/result width; legal values are 8, 16, 32 or 64.
- TAG_W, 6, width of the ROB/physical-register tag carried through unchanged.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  kills any in-flight operation.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_rs1  in  XLEN  multiplicand or dividend.
- in_rs2  in  XLEN  multiplier or divisor.
- in_tag  in  TAG_W  tag of the issuing instruction.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, in_ready=1, out_valid=0, out_result=0, out_tag=0, iteration counter=0.
- Accept: in_valid & in_ready & ~flush at an edge. The unit registers op, tag, the operand magnitudes, and result_sign.
  - rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  - rs2 is treated as signed for MULH, DIV and REM.
- State IDLE: in_ready=1. On accept, go to CALC with counter=0.
- State CALC: in_ready=0. Performs one radix-2 step per cycle.
  - Multiply: 2*XLEN-bit accumulator, shift-add.
  - Divide: restoring division, remainder XLEN+1 bits.
  - The counter increments each cycle. After XLEN steps, go to FIX.
- State FIX: one cycle.
  - Conditionally two's-complement the product, quotient or remainder.
  - Select the XLEN-bit output: low half for MUL, high half for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - Register out_result and out_tag, then go to DONE.
- Sign rules:
  - Product sign = sign1 XOR sign2.
  - Quotient sign = sign1 XOR sign2.
  - Remainder sign = dividend sign.
- State DONE: out_valid=1. out_result and out_tag are held stable until out_ready=1. On the out_ready edge, go to IDLE.
  - in_ready stays 0 in DONE, so there is no same-cycle re-accept. Throughput is one op per XLEN+3 cycles minimum.
- Latency: with the accept edge as cycle 0, out_valid is first high in cycle XLEN+2.
- Divide by zero (rs2=0):
  - DIV/DIVU return all ones.
  - REM/REMU return rs1 unmodified.
  - Computed in FIX by override, not by the datapath.
- Signed overflow (DIV/REM with rs1 = -2^(XLEN-1) and rs2 = -1):
  - DIV returns rs1.
  - REM returns 0.
- Flush:
  - In any state, flush=1 at an edge forces IDLE, out_valid=0 and counter=0.
  - A request presented in the same cycle as flush is not accepted.
  - A flush in DONE discards the pending result even if out_ready=1 in that cycle.
- Reset and flush mid-operation: both abandon all state. No partial result is ever presented.
- Simultaneous rst and flush: rst wins (same visible outcome).
- Operand registers are not updated outside IDLE, so changes on in_* during CALC/FIX/DONE are ignored.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined:
  - Divide-by-zero and signed-overflow cases skip CALC and FIX. IDLE goes directly to DONE with the override result registered, so out_valid is high in cycle 1.
  - MUL* with either operand zero does the same and returns 0.
- Undefined: every operation takes the full XLEN+2 latency, including these special cases.

Test Plan:
- Signed high multiply: XLEN=32, MULH rs1=0x80000000, rs2=0x80000000 -> out_result=0x40000000, out_valid high exactly 34 cycles after accept, out_tag equal to the issued tag.
- Mixed-sign and unsigned multiply:
  - MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU same operands -> 0xFFFFFFFE.
  - MUL same operands -> 0x00000001.
- Signed divide and remainder: DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU rs1=15, rs2=6 -> 2; REMU rs1=15, rs2=6 -> 3.
- Special cases:
  - DIVU rs1=0x1234, rs2=0 -> 0xFFFFFFFF.
  - REM rs1=0x1234, rs2=0 -> 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
  - Latency is 1 cycle with MDU_EARLY_OUT_EN defined and 34 cycles without.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises -> out_result and out_tag stable, in_ready=0 throughout. Raise out_ready -> in_ready=1 on the next cycle.
- Flush and reset:
  - Assert flush at CALC step 5 -> no out_valid. A new MUL 3*7 issued next cycle -> 21 with the new tag.
  - Assert rst during DONE -> out_valid=0 and in_ready=1 after that edge.

Source files
------------

// File: rtl/mdu_iterative_if.sv
// Request/result handshake bundle for mdu_iterative. The master modport is the
// reservation-station/CDB side; the slave modport is the unit itself.
interface mdu_iterative_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV32M/RV64M multiply/divide: shift-add multiply, restoring divide, final sign fix.
// Optional macro MDU_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiplies skip CALC/FIX.
module mdu_iterative #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    mdu_iterative_if.slave bus,
    output logic [1:0]     dbg_state
);
    // Handshakes: a request transfers on an edge with in_valid & in_ready & ~flush;
    // a result transfers on an edge with out_valid & out_ready, and out_result/out_tag
    // stay stable while out_valid is high and out_ready is low.
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;
    state_t state, state_nxt;

    logic             accept;
    logic             sgn1_in, sgn2_in, neg1_in, neg2_in, res_sign_in, zero_in, ovf_in;
    logic [XLEN-1:0]  mag1_in, mag2_in;
    logic             early_hit;
    logic [XLEN-1:0]  early_res;

    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  a_q, b_q, rs1_q, rem_q;
    logic             sign_q, zero_q, ovf_q;
    logic [2*XLEN-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, remv, fix_res;

    always_comb begin
        accept      = bus.in_valid & bus.in_ready & ~flush;
        sgn1_in     = (bus.in_op == 3'd1) | (bus.in_op == 3'd2) | (bus.in_op == 3'd4) | (bus.in_op == 3'd6);
        sgn2_in     = (bus.in_op == 3'd1) | (bus.in_op == 3'd4) | (bus.in_op == 3'd6);
        neg1_in     = sgn1_in & bus.in_rs1[XLEN-1];
        neg2_in     = sgn2_in & bus.in_rs2[XLEN-1];
        mag1_in     = neg1_in ? -bus.in_rs1 : bus.in_rs1;
        mag2_in     = neg2_in ? -bus.in_rs2 : bus.in_rs2;
        // Remainder follows the dividend; product and quotient follow sign1 ^ sign2.
        res_sign_in = (bus.in_op == 3'd6) ? neg1_in : (neg1_in ^ neg2_in);
        zero_in     = (bus.in_rs2 == '0);
        ovf_in      = sgn2_in & bus.in_op[2] & (bus.in_rs1 == MIN_VAL) & (bus.in_rs2 == '1);
    end

`ifdef MDU_EARLY_OUT_EN
    always_comb begin
        if (bus.in_op[2]) begin
            early_hit = zero_in | ovf_in;
            if (!bus.in_op[1]) early_res = zero_in ? '1 : bus.in_rs1;
            else               early_res = zero_in ? bus.in_rs1 : '0;
        end else begin
            early_hit = (bus.in_rs1 == '0) | zero_in;
            early_res = '0;
        end
    end
`else
    assign early_hit = 1'b0;
    assign early_res = '0;
`endif

    // acc holds {partial product, multiplier} for multiplies and {unused, quotient shifter} for divides.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_q} : '0);
        div_shift = {rem_q, acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        prod      = sign_q ? -acc : acc;
        quo       = sign_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        remv      = sign_q ? -rem_q : rem_q;
        case (op_q)
            3'd0:             fix_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fix_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fix_res = zero_q ? '1 : (ovf_q ? rs1_q : quo);
            default:          fix_res = zero_q ? rs1_q : (ovf_q ? '0 : remv);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept) state_nxt = early_hit ? S_DONE : S_CALC;
                S_CALC:  if (cnt == CNT_W'(XLEN - 1)) state_nxt = S_FIX;
                S_FIX:   state_nxt = S_DONE;
                S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state == S_IDLE);
        bus.out_valid = (state == S_DONE);
        dbg_state     = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q           <= '0;
            tag_q          <= '0;
            a_q            <= '0;
            b_q            <= '0;
            rs1_q          <= '0;
            rem_q          <= '0;
            sign_q         <= 1'b0;
            zero_q         <= 1'b0;
            ovf_q          <= 1'b0;
            acc            <= '0;
            cnt            <= '0;
            bus.out_result <= '0;
            bus.out_tag    <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= bus.in_op;
                        tag_q  <= bus.in_tag;
                        a_q    <= mag1_in;
                        b_q    <= mag2_in;
                        rs1_q  <= bus.in_rs1;
                        sign_q <= res_sign_in;
                        zero_q <= zero_in;
                        ovf_q  <= ovf_in;
                        acc    <= {{XLEN{1'b0}}, (bus.in_op[2] ? mag1_in : mag2_in)};
                        rem_q  <= '0;
                        cnt    <= '0;
                        if (early_hit) begin
                            bus.out_result <= early_res;
                            bus.out_tag    <= bus.in_tag;
                        end
                    end
                end
                S_CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (op_q[2]) begin
                        acc[XLEN-1:0] <= {acc[XLEN-2:0], ~div_diff[XLEN]};
                        rem_q         <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                    end else begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                    end
                end
                S_FIX: begin
                    bus.out_result <= fix_res;
                    bus.out_tag    <= tag_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed vector table, multi-cycle corner
// sequences (backpressure, flush, reset) and random ops against an arithmetic reference.
module tb_mdu_iterative;
  localparam int XLEN  = 32;
  localparam int TAG_W = 6;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] dbg_state;

  mdu_iterative_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();

  mdu_iterative #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    string           nm;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] e;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic [2:0] op,
                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input logic [XLEN-1:0] e);
    vec_t v;
    v.nm = nm; v.op = op; v.a = a; v.b = b; v.e = e;
    return v;
  endfunction

  // Reference model straight from the RISC-V M rules, using 64-bit arithmetic.
  function automatic logic [XLEN-1:0] ref_mdu(input logic [2:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0, 3'd1: p = 64'(sa * sb);
      3'd2:       p = 64'(sa * ub);
      3'd3:       p = 64'(ua * ub);
      default:    p = '0;
    endcase
    case (op)
      3'd0:             return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4:             return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      3'd5:             return (b == 0) ? 32'hFFFF_FFFF : (a / b);
      3'd6:             return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default:          return (b == 0) ? a : (a % b);
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    logic special;
    if (op[2]) special = (b == 0) || (((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    else       special = (a == 0) || (b == 0);
`ifdef MDU_EARLY_OUT_EN
    return special ? 1 : XLEN + 2;
`else
    return (special === 1'bx) ? 0 : XLEN + 2;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("issue_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.in_tag   = tag;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Latency in cycles with the accept edge as cycle 0; -1 on timeout.
  task automatic wait_valid(output int lat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = bus.out_valid ? n + 1 : -1;
  endtask

  task automatic consume(input string nm);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({nm, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    chk({nm, "_ready_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic do_op(input string nm, input logic [2:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] e,
                       input logic [TAG_W-1:0] tag);
    int lat;
    logic [XLEN-1:0] want;
    issue(op, a, b, tag);
    exp_q.push_back(e);
    wait_valid(lat);
    want = exp_q.pop_front();
    chk({nm, "_result"}, 64'(bus.out_result), 64'(want));
    chk({nm, "_tag"}, 64'(bus.out_tag), 64'(tag));
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat(op, a, b)));
    consume(nm);
  endtask

  function automatic logic [XLEN-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 9));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int lat;
    logic [XLEN-1:0] held_res, e;
    logic [TAG_W-1:0] held_tag;
    logic [2:0] op;
    logic [XLEN-1:0] a, b;

    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready",   64'(bus.in_ready),   64'd1);
    chk("rst_out_valid",  64'(bus.out_valid),  64'd0);
    chk("rst_out_result", 64'(bus.out_result), 64'd0);
    chk("rst_out_tag",    64'(bus.out_tag),    64'd0);
    chk("rst_state",      64'(dbg_state),      64'd0);

    vecs.push_back(mk("mulh_min_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000));
    vecs.push_back(mk("mulhsu_m1",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    vecs.push_back(mk("mulhu_m1",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE));
    vecs.push_back(mk("mul_m1",        3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001));
    vecs.push_back(mk("div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD));
    vecs.push_back(mk("rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF));
    vecs.push_back(mk("divu_15_6",     3'd5, 32'd15,        32'd6,         32'd2));
    vecs.push_back(mk("remu_15_6",     3'd7, 32'd15,        32'd6,         32'd3));
    vecs.push_back(mk("divu_by0",      3'd5, 32'h1234,      32'd0,         32'hFFFF_FFFF));
    vecs.push_back(mk("rem_by0",       3'd6, 32'h1234,      32'd0,         32'h1234));
    vecs.push_back(mk("div_ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000));
    vecs.push_back(mk("rem_ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0));
    vecs.push_back(mk("mul_zero",      3'd0, 32'd0,         32'd5,         32'd0));
    vecs.push_back(mk("mulh_maxpos",   3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF));
    vecs.push_back(mk("divu_big_1",    3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF));
    vecs.push_back(mk("remu_by0",      3'd7, 32'd7,         32'd0,         32'd7));
    vecs.push_back(mk("div_7_m2",      3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD));
    vecs.push_back(mk("rem_7_m2",      3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1));
    vecs.push_back(mk("div_by0",       3'd4, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF));

    foreach (vecs[i])
      do_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, TAG_W'(i + 1));

    // Backpressure with in_* wiggling during the operation.
    issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 6'd33);
    bus.in_valid = 1'b1;
    bus.in_op    = 3'd0;
    bus.in_rs1   = 32'($urandom);
    bus.in_rs2   = 32'($urandom);
    bus.in_tag   = 6'd12;
    wait_valid(lat);
    bus.in_valid = 1'b0;
    held_res = bus.out_result;
    held_tag = bus.out_tag;
    chk("bp_result", 64'(held_res), 64'(ref_mdu(3'd3, 32'hDEAD_BEEF, 32'h1234_5678)));
    chk("bp_tag", 64'(held_tag), 64'd33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_result", 64'(bus.out_result), 64'(held_res));
      chk("bp_hold_tag",    64'(bus.out_tag),    64'(held_tag));
      chk("bp_hold_valid",  64'(bus.out_valid),  64'd1);
      chk("bp_in_ready",    64'(bus.in_ready),   64'd0);
    end
    consume("bp");

    // Flush at CALC step 5 with a competing request in the flush cycle.
    issue(3'd5, 32'hCAFE_F00D, 32'd3, 6'd5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = 3'd0;
    bus.in_rs1   = 32'd9;
    bus.in_rs2   = 32'd9;
    bus.in_tag   = 6'd9;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_calc_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_calc_ready", 64'(bus.in_ready),  64'd1);
    chk("flush_calc_state", 64'(dbg_state),     64'd0);
    do_op("after_flush_mul", 3'd0, 32'd3, 32'd7, 32'd21, 6'd10);

    // Flush in DONE discards the result even with out_ready high.
    issue(3'd4, 32'd100, 32'd7, 6'd20);
    wait_valid(lat);
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    chk("flush_done_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_done_ready", 64'(bus.in_ready),  64'd1);
    @(posedge clk);
    #1;
    chk("flush_done_quiet", 64'(bus.out_valid), 64'd0);

    // Reset during DONE.
    issue(3'd2, 32'hF000_0001, 32'h0000_0010, 6'd44);
    wait_valid(lat);
    chk("rstdone_pre_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstdone_valid",  64'(bus.out_valid),  64'd0);
    chk("rstdone_ready",  64'(bus.in_ready),   64'd1);
    chk("rstdone_result", 64'(bus.out_result), 64'd0);
    chk("rstdone_tag",    64'(bus.out_tag),    64'd0);

    // Random ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      e  = ref_mdu(op, a, b);
      do_op("rand", op, a, b, e, TAG_W'($urandom_range(0, 63)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
